lcd_timing_ctrl: RTL and testbench

Timing and power-sequencing controller for the 480x272 RGB LCD panel.
- Generates the raster counters (hcount_reg, Vcount_reg), the active-area flags (flagh, flagv) and the output-stage strobe (rgb_en) consumed by the overlay/colour stages.
- Generates the panel-side sync, data-enable, display-on and backlight signals, pipelined to match the two-register colour path.
- Sequences panel warm-up and orderly shutdown through a small state machine.

---
 rtl/lcd_timing_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_lcd_timing_ctrl.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/lcd_timing_ctrl.sv
// Raster timing and power sequencing for an RGB LCD panel.
// Generates the counters, active flags, panel syncs/DE (aligned to the colour pipeline), and DISP/backlight control.
module lcd_timing_ctrl #(
  parameter int unsigned H_ACTIVE    = 480,
  parameter int unsigned H_FP        = 2,
  parameter int unsigned H_SYNC      = 41,
  parameter int unsigned H_BP        = 2,
  parameter int unsigned V_ACTIVE    = 272,
  parameter int unsigned V_FP        = 2,
  parameter int unsigned V_SYNC      = 10,
  parameter int unsigned V_BP        = 2,
  parameter int unsigned WARM_FRAMES = 4
) (
  input  logic       clk_lcd,
  input  logic       rst,
  input  logic       enable,
  output logic [9:0] hcount_reg,
  output logic [8:0] Vcount_reg,
  output logic       flagh,
  output logic       flagv,
  output logic       rgb_en,
  output logic       hsync_n,
  output logic       vsync_n,
  output logic       de,
  output logic       disp_on,
  output logic       bl_en,
  output logic       frame_start,
  output logic [7:0] frame_cnt
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_STOP  = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [8:0] V_LAST   = 9'(V_TOTAL - 1);
  localparam logic [8:0] V_ACT    = 9'(V_ACTIVE);
  localparam logic [8:0] VS_FIRST = 9'(V_ACTIVE + V_FP);
  localparam logic [8:0] VS_STOP  = 9'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [3:0] WARM_LAST = 4'(WARM_FRAMES - 1);

  // Two register stages on the panel path to match the colour registers.
  localparam int PIPE_DEPTH = 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WARMUP,
    S_RUN,
    S_STOPPING
  } state_t;

  state_t     state_q, state_d;
  logic [9:0] h_q, h_d;
  logic [8:0] v_q, v_d;
  logic [3:0] warm_q, warm_d;
  logic [7:0] fcnt_q, fcnt_d;
  logic       disp_on_q, disp_on_d;
  logic       bl_en_q, bl_en_d;

  logic       running;
  logic       h_wrap;
  logic       frame_wrap;
  logic       flagh_c;
  logic       flagv_c;
  logic       de_gate;
  logic       de_raw;
  logic       hs_raw_n;
  logic       vs_raw_n;
  logic       frame_start_c;

  // Per stage: {de, hsync_n, vsync_n}
  logic [2:0] pipe_q [PIPE_DEPTH];
  logic [2:0] pipe_d [PIPE_DEPTH];

  // Stage 0: decode straight off the raw counters.
  always_comb begin
    running       = (state_q != S_IDLE);
    h_wrap        = (h_q == H_LAST);
    frame_wrap    = h_wrap && (v_q == V_LAST);
    flagh_c       = running && (h_q < H_ACT);
    flagv_c       = running && (v_q < V_ACT);
    de_gate       = (state_q == S_RUN);
    de_raw        = flagh_c && flagv_c && de_gate;
    hs_raw_n      = !(running && (h_q >= HS_FIRST) && (h_q < HS_STOP));
    vs_raw_n      = !(running && (v_q >= VS_FIRST) && (v_q < VS_STOP));
    frame_start_c = running && (h_q == '0) && (v_q == '0);
  end

  always_comb begin
    state_d = state_q;
    warm_d  = warm_q;
    case (state_q)
      S_IDLE: begin
        warm_d = '0;
        if (enable) state_d = S_WARMUP;
      end
      S_WARMUP: begin
        if (!enable) begin
          state_d = S_STOPPING;
        end else if (frame_wrap) begin
          warm_d = 4'(warm_q + 4'd1);
          // Switching at the wrap makes RUN begin exactly at the next origin.
          if (warm_q == WARM_LAST) state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (!enable) state_d = S_STOPPING;
      end
      S_STOPPING: begin
        if (frame_wrap) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    h_d = '0;
    v_d = '0;
    if (running) begin
      h_d = h_wrap ? 10'd0 : 10'(h_q + 10'd1);
      v_d = v_q;
      if (h_wrap) v_d = (v_q == V_LAST) ? 9'd0 : 9'(v_q + 9'd1);
    end
    fcnt_d    = 8'(fcnt_q + {7'd0, frame_start_c});
    disp_on_d = (state_d != S_IDLE);
    bl_en_d   = (state_d == S_RUN);
  end

  always_ff @(posedge clk_lcd) begin
    if (rst) begin
      state_q   <= S_IDLE;
      h_q       <= '0;
      v_q       <= '0;
      warm_q    <= '0;
      fcnt_q    <= '0;
      disp_on_q <= 1'b0;
      bl_en_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      h_q       <= h_d;
      v_q       <= v_d;
      warm_q    <= warm_d;
      fcnt_q    <= fcnt_d;
      disp_on_q <= disp_on_d;
      bl_en_q   <= bl_en_d;
    end
  end

  generate
    for (genvar gi = 0; gi < PIPE_DEPTH; gi++) begin : g_pipe
      if (gi == 0) begin : g_first
        assign pipe_d[gi] = {de_raw, hs_raw_n, vs_raw_n};
      end else begin : g_next
        assign pipe_d[gi] = pipe_q[gi-1];
      end

      always_ff @(posedge clk_lcd) begin
        if (rst) begin
          pipe_q[gi] <= 3'b011;
        end else begin
          pipe_q[gi] <= pipe_d[gi];
        end
      end
    end
  endgenerate

  assign hcount_reg  = h_q;
  assign Vcount_reg  = v_q;
  assign flagh       = flagh_c;
  assign flagv       = flagv_c;
  assign frame_start = frame_start_c;
  assign frame_cnt   = fcnt_q;
  assign disp_on     = disp_on_q;
  assign bl_en       = bl_en_q;
  // The first stage's DE copy is the colour-register capture strobe.
  assign rgb_en      = pipe_q[0][2];
  assign de          = pipe_q[PIPE_DEPTH-1][2];
  assign hsync_n     = pipe_q[PIPE_DEPTH-1][1];
  assign vsync_n     = pipe_q[PIPE_DEPTH-1][0];

endmodule

// File: tb/tb_lcd_timing_ctrl.sv
// Directed bench for lcd_timing_ctrl on a shrunken raster (15 clocks x 8 lines, 2 warm-up frames)
// so warm-up, stop, frame-counter wrap and mid-frame reset all fit in a short run.
module tb_lcd_timing_ctrl;

  logic       clk_lcd = 1'b0;
  logic       rst     = 1'b1;
  logic       enable  = 1'b0;
  logic [9:0] hcount_reg;
  logic [8:0] Vcount_reg;
  logic       flagh, flagv, rgb_en, hsync_n, vsync_n, de, disp_on, bl_en, frame_start;
  logic [7:0] frame_cnt;

  always #5 clk_lcd = ~clk_lcd;

  // H: active 0..7, FP 8..9, sync 10..12, BP 13..14.  V: active 0..3, FP 4, sync 5..6, BP 7.
  lcd_timing_ctrl #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .WARM_FRAMES(2)
  ) dut (
    .clk_lcd    (clk_lcd),
    .rst        (rst),
    .enable     (enable),
    .hcount_reg (hcount_reg),
    .Vcount_reg (Vcount_reg),
    .flagh      (flagh),
    .flagv      (flagv),
    .rgb_en     (rgb_en),
    .hsync_n    (hsync_n),
    .vsync_n    (vsync_n),
    .de         (de),
    .disp_on    (disp_on),
    .bl_en      (bl_en),
    .frame_start(frame_start),
    .frame_cnt  (frame_cnt)
  );

  // fl = {flagh, flagv, rgb_en, hsync_n, vsync_n, de, disp_on, bl_en, frame_start}
  typedef struct {
    int         n;
    logic       en;
    logic [9:0] h;
    logic [8:0] v;
    logic [8:0] fl;
    logic [7:0] fc;
  } vec_t;

  vec_t vecs [13];

  int checks   = 0;
  int failures = 0;
  int k;
  int de_tot, hs_tot, vs_tot, de_run, de_max, hs_run, hs_max, vs_run, vs_max, hs_fall_h;
  logic       prev_hs;
  logic [7:0] fc_saved;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_lcd);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [35:0] snap();
    return {hcount_reg, Vcount_reg, flagh, flagv, rgb_en, hsync_n, vsync_n,
            de, disp_on, bl_en, frame_start, frame_cnt};
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // t = cycles since the first WARMUP cycle (origin of frame 1); RUN starts at t=240.
    vecs[0]  = '{0,   1'b0, 10'd0,  9'd0, 9'b000110000, 8'd0};  // idle after reset
    vecs[1]  = '{1,   1'b1, 10'd0,  9'd0, 9'b110110101, 8'd0};  // t=0
    vecs[2]  = '{1,   1'b1, 10'd1,  9'd0, 9'b110110100, 8'd1};  // t=1
    vecs[3]  = '{11,  1'b1, 10'd12, 9'd0, 9'b010010100, 8'd1};  // t=12 hsync low
    vecs[4]  = '{65,  1'b1, 10'd2,  9'd5, 9'b100100100, 8'd1};  // t=77 vsync low
    vecs[5]  = '{43,  1'b1, 10'd0,  9'd0, 9'b110110101, 8'd1};  // t=120 frame 2
    vecs[6]  = '{119, 1'b1, 10'd14, 9'd7, 9'b000010100, 8'd2};  // t=239 last warm cycle
    vecs[7]  = '{1,   1'b1, 10'd0,  9'd0, 9'b110110111, 8'd2};  // t=240 RUN entry
    vecs[8]  = '{1,   1'b1, 10'd1,  9'd0, 9'b111110110, 8'd3};  // rgb_en up
    vecs[9]  = '{1,   1'b1, 10'd2,  9'd0, 9'b111111110, 8'd3};  // de up
    vecs[10] = '{6,   1'b1, 10'd8,  9'd0, 9'b011111110, 8'd3};  // h=480-equivalent
    vecs[11] = '{1,   1'b1, 10'd9,  9'd0, 9'b010111110, 8'd3};  // rgb_en down
    vecs[12] = '{1,   1'b1, 10'd10, 9'd0, 9'b010110110, 8'd3};  // de down

    rst = 1'b1;
    enable = 1'b0;
    step(2);
    rst = 1'b0;

    for (int i = 0; i < 100; i++) begin
      step(1);
      chk("idle_hold", 64'({hcount_reg, Vcount_reg, de, rgb_en, disp_on, bl_en, frame_start, hsync_n, vsync_n}),
          64'({10'd0, 9'd0, 7'b0000011}));
    end

    for (int i = 0; i < 13; i++) begin
      enable = vecs[i].en;
      step(vecs[i].n);
      chk($sformatf("vec%0d", i), 64'(snap()),
          64'({vecs[i].h, vecs[i].v, vecs[i].fl, vecs[i].fc}));
    end

    // One full frame in RUN: totals and run lengths of de/hsync/vsync.
    de_tot = 0; hs_tot = 0; vs_tot = 0;
    de_run = 0; de_max = 0; hs_run = 0; hs_max = 0; vs_run = 0; vs_max = 0;
    hs_fall_h = -1;
    prev_hs = hsync_n;
    for (int i = 0; i < 120; i++) begin
      step(1);
      if (de) begin de_tot++; de_run++; if (de_run > de_max) de_max = de_run; end else de_run = 0;
      if (!hsync_n) begin hs_tot++; hs_run++; if (hs_run > hs_max) hs_max = hs_run; end else hs_run = 0;
      if (!vsync_n) begin vs_tot++; vs_run++; if (vs_run > vs_max) vs_max = vs_run; end else vs_run = 0;
      if (prev_hs && !hsync_n && hs_fall_h < 0) hs_fall_h = int'(hcount_reg);
      prev_hs = hsync_n;
    end
    chk("de_total",    64'(de_tot), 64'(32));
    chk("de_run",      64'(de_max), 64'(8));
    chk("hs_total",    64'(hs_tot), 64'(24));
    chk("hs_run",      64'(hs_max), 64'(3));
    chk("hs_fall_h",   64'(hs_fall_h), 64'(12));
    chk("vs_total",    64'(vs_tot), 64'(30));
    chk("vs_run",      64'(vs_max), 64'(30));

    // Orderly stop from mid-frame, with enable re-raised during STOPPING.
    k = 0;
    while (!(hcount_reg == 10'd3 && Vcount_reg == 9'd2 && bl_en) && k < 200) begin step(1); k++; end
    chk("wait_stop_point", 64'(k < 200), 64'(1));
    enable = 1'b0;
    step(1);
    chk("stop_bl_disp", 64'({bl_en, disp_on}), 64'(2'b01));
    step(1);
    chk("stop_rgb_en", 64'(rgb_en), 64'(0));
    step(1);
    chk("stop_de", 64'(de), 64'(0));
    enable = 1'b1;
    step(5);
    chk("stop_ignores_en", 64'({bl_en, disp_on, de}), 64'(3'b010));
    k = 0;
    while (!(hcount_reg == 10'd14 && Vcount_reg == 9'd7) && k < 200) begin step(1); k++; end
    chk("wait_stop_wrap", 64'(k < 200), 64'(1));
    chk("stop_last_disp", 64'({disp_on, bl_en}), 64'(2'b10));
    step(1);
    chk("stop_idle", 64'({hcount_reg, Vcount_reg, flagh, flagv, rgb_en, hsync_n, vsync_n, de, disp_on, bl_en, frame_start}),
        64'({10'd0, 9'd0, 9'b000110000}));
    fc_saved = frame_cnt;
    step(1);
    chk("rewarm", 64'({disp_on, frame_start, bl_en}), 64'(3'b110));
    step(1);
    chk("rewarm_fc", 64'(frame_cnt), 64'(8'(fc_saved + 8'd1)));

    k = 0;
    while (!bl_en && k < 400) begin step(1); k++; end
    chk("wait_run2", 64'(k < 400), 64'(1));
    chk("run2_origin", 64'({hcount_reg, Vcount_reg, frame_start}), 64'({10'd0, 9'd0, 1'b1}));

    // frame_cnt wraps 255 -> 0.
    k = 0;
    while (frame_cnt != 8'd255 && k < 40000) begin step(1); k++; end
    chk("wait_fc255", 64'(k < 40000), 64'(1));
    k = 0;
    while (!frame_start && k < 200) begin step(1); k++; end
    chk("wait_fs", 64'(k < 200), 64'(1));
    step(1);
    chk("fc_wrap", 64'(frame_cnt), 64'(0));

    // Single-cycle reset mid-line in RUN.
    k = 0;
    while (!(hcount_reg == 10'd6 && Vcount_reg == 9'd3) && k < 200) begin step(1); k++; end
    chk("wait_rst_point", 64'(k < 200), 64'(1));
    chk("pre_rst_active", 64'({de, rgb_en, bl_en}), 64'(3'b111));
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("mid_reset", 64'(snap()), 64'({10'd0, 9'd0, 9'b000110000, 8'd0}));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
